// File: rtl/rxctrl.sv
// Receive-side controller: bit-clock divider, shift-register enable gating,
// and a DEPTH-entry byte FIFO with empty/full/overrun status and interrupt.
module rxctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DIV_W = 16
) (
  input  logic             i_Pclk,
  input  logic             i_Reset,
  input  logic             i_Rx_En,
  input  logic [DIV_W-1:0] i_Divisor,
  input  logic             i_Flush,
  input  logic             i_Clr_Overrun,
  input  logic             i_Irq_En,
  output logic             o_Bclk,
  output logic             o_Shift_Enable,
  input  logic [7:0]       i_Shift_Data,
  input  logic             i_Shift_Done,
  input  logic             i_Rd,
  output logic [7:0]       o_Rd_Data,
  output logic             o_Rd_Valid,
  output logic [AW:0]      o_Count,
  output logic             o_Empty,
  output logic             o_Full,
  output logic             o_Overrun,
  output logic             o_Irq
);

  typedef enum logic {ST_IDLE = 1'b0, ST_ARMED = 1'b1} state_t;

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             bclk_q, bclk_d;
  logic             shift_en_q, shift_en_d;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             overrun_q, overrun_d;
  logic             rd_valid_q, rd_valid_d;
  logic [7:0]       rd_data_q;
  logic [7:0]       mem [DEPTH];

  logic             empty, full, pop, push, drop;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_CNT);

  // A pop frees the slot a same-cycle push needs, so a full FIFO only drops
  // the incoming byte when nobody is reading; flush discards everything.
  assign pop  = i_Rd & ~empty & ~i_Flush;
  assign push = i_Shift_Done & (~full | pop) & ~i_Flush;
  assign drop = i_Shift_Done & full & ~pop & ~i_Flush;

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    bclk_d     = bclk_q;
    shift_en_d = shift_en_q;
    case (state_q)
      ST_IDLE: begin
        div_cnt_d  = '0;
        bclk_d     = 1'b1;
        shift_en_d = 1'b0;
        if (i_Rx_En) begin
          state_d    = ST_ARMED;
          shift_en_d = 1'b1;
        end
      end
      ST_ARMED: begin
        if (!i_Rx_En) begin
          state_d    = ST_IDLE;
          shift_en_d = 1'b0;
          div_cnt_d  = '0;
          bclk_d     = 1'b1;
        end else if (div_cnt_q == i_Divisor) begin
          div_cnt_d = '0;
          bclk_d    = ~bclk_q;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_Flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
    overrun_d  = (overrun_q & ~i_Clr_Overrun) | drop;
    rd_valid_d = pop;
  end

  always_ff @(posedge i_Pclk) begin
    if (i_Reset) begin
      state_q    <= ST_IDLE;
      div_cnt_q  <= '0;
      bclk_q     <= 1'b1;
      shift_en_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      bclk_q     <= bclk_d;
      shift_en_q <= shift_en_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Storage has no reset so it maps onto block RAM; the read port is registered.
  always_ff @(posedge i_Pclk) begin
    if (push && !i_Reset) mem[wr_ptr_q] <= i_Shift_Data;
  end

  always_ff @(posedge i_Pclk) begin
    if (i_Reset)  rd_data_q <= '0;
    else if (pop) rd_data_q <= mem[rd_ptr_q];
  end

  assign o_Bclk         = bclk_q;
  assign o_Shift_Enable = shift_en_q;
  assign o_Rd_Data      = rd_data_q;
  assign o_Rd_Valid     = rd_valid_q;
  assign o_Count        = count_q;
  assign o_Empty        = empty;
  assign o_Full         = full;
  assign o_Overrun      = overrun_q;
  assign o_Irq          = i_Irq_En & (~empty | overrun_q);

endmodule

// File: tb/tb_rxctrl.sv
// Bench for rxctrl: directed scenarios plus randomized traffic, every cycle
// checked against a queue-based model of the receive controller.
module tb_rxctrl;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        srst, rx_en, flush, clr_ovr, irq_en, done, rd;
  logic [15:0] div;
  logic [7:0]  sdata;

  logic        o_bclk, o_shift_en, o_rd_valid, o_empty, o_full, o_ovr, o_irq;
  logic [7:0]  o_rd_data;
  logic [3:0]  o_count;

  int total = 0;
  int bad   = 0;

  // Model state: queue of stored bytes plus the visible flags.
  byte unsigned mq[$];
  bit           m_armed, m_bclk, m_ovr, m_rv;
  int           m_ticks;
  logic [7:0]   m_rdata;
  bit           check_en = 1'b0;

  always #5 clk = ~clk;

  rxctrl #(.DEPTH(8), .AW(3), .DIV_W(16)) dut (
    .i_Pclk(clk), .i_Reset(srst), .i_Rx_En(rx_en), .i_Divisor(div),
    .i_Flush(flush), .i_Clr_Overrun(clr_ovr), .i_Irq_En(irq_en),
    .o_Bclk(o_bclk), .o_Shift_Enable(o_shift_en),
    .i_Shift_Data(sdata), .i_Shift_Done(done), .i_Rd(rd),
    .o_Rd_Data(o_rd_data), .o_Rd_Valid(o_rd_valid), .o_Count(o_count),
    .o_Empty(o_empty), .o_Full(o_full), .o_Overrun(o_ovr), .o_Irq(o_irq)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit ovr_evt;
    ovr_evt = 1'b0;
    if (srst) begin
      mq.delete();
      m_armed = 0; m_bclk = 1; m_ticks = 0; m_ovr = 0; m_rv = 0; m_rdata = 8'h00;
      return;
    end
    m_rv = 0;
    // Bit clock: half period is div+1 cycles counted from arming.
    if (!m_armed) begin
      if (rx_en) begin m_armed = 1; m_ticks = 0; m_bclk = 1; end
    end else if (!rx_en) begin
      m_armed = 0; m_bclk = 1; m_ticks = 0;
    end else begin
      m_ticks++;
      if (m_ticks == int'(div) + 1) begin m_bclk = ~m_bclk; m_ticks = 0; end
    end
    if (flush) begin
      mq.delete();
    end else begin
      if (rd && mq.size() > 0) begin
        m_rdata = mq.pop_front();
        m_rv = 1;
      end
      if (done) begin
        if (mq.size() < DEPTH) mq.push_back(sdata);
        else ovr_evt = 1'b1;
      end
    end
    m_ovr = (m_ovr && !clr_ovr) || ovr_evt;
  endtask

  task automatic compare_all();
    if (!check_en) return;
    chk("bclk",     o_bclk,     m_bclk);
    chk("shift_en", o_shift_en, m_armed);
    chk("rd_valid", o_rd_valid, m_rv);
    chk("rd_data",  o_rd_data,  m_rdata);
    chk("count",    o_count,    mq.size());
    chk("empty",    o_empty,    mq.size() == 0);
    chk("full",     o_full,     mq.size() == DEPTH);
    chk("overrun",  o_ovr,      m_ovr);
    chk("irq",      o_irq,      irq_en && (mq.size() != 0 || m_ovr));
  endtask

  // One clock: model follows the edge, outputs are compared on the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    done = 1; sdata = d; cyc(); done = 0;
  endtask

  task automatic read1();
    rd = 1; cyc(); rd = 0;
  endtask

  initial begin
    srst = 1; rx_en = 0; flush = 0; clr_ovr = 0; irq_en = 0; done = 0; rd = 0;
    div = 16'd3; sdata = 8'h00;
    @(negedge clk); #1;
    check_en = 1'b1;
    cyc();
    chk("rst_count", o_count, 0);
    chk("rst_empty", o_empty, 1);
    chk("rst_bclk", o_bclk, 1);

    // Bit clock divide by 8 with divisor 3
    srst = 0; rx_en = 1; div = 16'd3; cyc();
    chk("s1_shen", o_shift_en, 1);
    chk("s1_bclk_start", o_bclk, 1);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk("s1_bclk", o_bclk, (k < 4 || k == 8) ? 1 : 0);
    end

    // Two bytes in, two bytes out
    push_byte(8'hA5); push_byte(8'h3C);
    chk("s2_count", o_count, 2);
    read1();
    chk("s2_v0", o_rd_valid, 1); chk("s2_d0", o_rd_data, 8'hA5);
    read1();
    chk("s2_v1", o_rd_valid, 1); chk("s2_d1", o_rd_data, 8'h3C);
    cyc();
    chk("s2_empty", o_empty, 1); chk("s2_novalid", o_rd_valid, 0);

    // Fill to full, overrun on the ninth byte
    for (int i = 0; i < 9; i++) begin
      push_byte(8'h10 + 8'(i));
      if (i == 7) begin chk("s3_full", o_full, 1); chk("s3_noovr", o_ovr, 0); end
    end
    chk("s3_ovr", o_ovr, 1); chk("s3_count", o_count, 8);
    for (int i = 0; i < 8; i++) begin
      read1();
      chk("s3_data", o_rd_data, 8'h10 + 8'(i));
    end
    clr_ovr = 1; cyc(); clr_ovr = 0;
    chk("s3_clr", o_ovr, 0);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) push_byte(8'h20 + 8'(i));
    done = 1; sdata = 8'h99; rd = 1; cyc(); done = 0; rd = 0;
    chk("s4_count", o_count, 8); chk("s4_ovr", o_ovr, 0); chk("s4_old", o_rd_data, 8'h20);
    for (int i = 0; i < 8; i++) begin
      read1();
      if (i == 7) chk("s4_last", o_rd_data, 8'h99);
    end

    // Disable mid-run keeps FIFO; flush empties it
    for (int k = 0; k < 3; k++) cyc();
    rx_en = 0; cyc();
    chk("s5_shen", o_shift_en, 0); chk("s5_bclk", o_bclk, 1);
    push_byte(8'h55); push_byte(8'h66);
    chk("s5_count", o_count, 2);
    flush = 1; cyc(); flush = 0;
    chk("s5_flush_cnt", o_count, 0); chk("s5_flush_empty", o_empty, 1);

    // Reset with bytes queued and Bclk low
    irq_en = 1; rx_en = 1; div = 16'd0; cyc();
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
    for (int k = 0; k < 4 && m_bclk; k++) cyc();
    chk("s6_bclk_low", o_bclk, 0);
    chk("s6_irq_pre", o_irq, 1);
    srst = 1; cyc();
    chk("s6_count", o_count, 0); chk("s6_bclk", o_bclk, 1); chk("s6_shen", o_shift_en, 0);
    chk("s6_rdata", o_rd_data, 0); chk("s6_irq", o_irq, 0); chk("s6_ovr", o_ovr, 0);
    srst = 0; rd = 1; cyc(); rd = 0;
    chk("s6_rd_empty", o_rd_valid, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      srst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0) rx_en = ~rx_en;
      if (!m_armed && !rx_en && $urandom_range(0, 3) == 0) div = 16'($urandom_range(0, 5));
      done    = ($urandom_range(0, 99) < 30);
      sdata   = 8'($urandom);
      rd      = ($urandom_range(0, 99) < ((n < 1500) ? 15 : 45));
      flush   = ($urandom_range(0, 99) < 2);
      clr_ovr = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 19) == 0) irq_en = ~irq_en;
      cyc();
    end
    srst = 0; done = 0; rd = 0; flush = 0; clr_ovr = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
